// File: rtl/pong_pkg.sv
// Shared types and constants for the pong display path: scheduler state,
// frame-counter sizing helper and the power-on ball/paddle positions.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } sched_state_t;

  // 16 rows x 2^(TIMERWIDTH+1) cycles per row
  function automatic int frame_bits(input int timerwidth);
    return timerwidth + 5;
  endfunction

  localparam logic [3:0]  PONG_RESET_X      = 4'd7;
  localparam logic [3:0]  PONG_RESET_Y      = 4'd7;
  localparam logic [15:0] PONG_RESET_PADDLE = 16'h03C0;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter mirroring the screen scan. Emits a registered
// frame_start / due pair plus their one-cycle-ahead versions for the scheduler.
module frame_timer
  import pong_pkg::*;
#(
  parameter int TIMERWIDTH      = 12,
  parameter int FRAMES_PER_TICK = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause,
  output logic o_frame_start,
  output logic o_due,
  output logic o_fs_next,
  output logic o_due_next
);

  localparam int         FB       = frame_bits(TIMERWIDTH);
  localparam logic [7:0] LAST_DIV = 8'(FRAMES_PER_TICK - 1);

  logic [FB-1:0] r_fc;
  logic [7:0]    r_fdiv;
  logic          r_frame_start;
  logic          r_due;
  logic          w_fs_next;
  logic          w_due_next;

  // fc wraps from all-ones to zero, so the next cycle is a frame start
  // exactly when the counter is saturated.
  assign w_fs_next  = (r_fc == {FB{1'b1}});
  assign w_due_next = w_fs_next && (r_fdiv == LAST_DIV) && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fc          <= '0;
      r_fdiv        <= '0;
      r_frame_start <= 1'b0;
      r_due         <= 1'b0;
    end else begin
      r_fc          <= r_fc + 1'b1;
      r_frame_start <= w_fs_next;
      r_due         <= w_due_next;
      if (r_frame_start) begin
        r_fdiv <= (r_fdiv == LAST_DIV) ? 8'd0 : r_fdiv + 8'd1;
      end
    end
  end

  assign o_frame_start = r_frame_start;
  assign o_due         = r_due;
  assign o_fs_next     = w_fs_next;
  assign o_due_next    = w_due_next;

endmodule

// File: rtl/frame_scheduler.sv
// Paces game updates to frame boundaries: ticks game logic, accepts the next
// state over valid/ready, and double-buffers it into the displayed registers.
module frame_scheduler
  import pong_pkg::*;
#(
  parameter int          TIMERWIDTH      = 12,
  parameter int          FRAMES_PER_TICK = 8,
  parameter logic [3:0]  RESET_X         = PONG_RESET_X,
  parameter logic [3:0]  RESET_Y         = PONG_RESET_Y,
  parameter logic [15:0] RESET_PADDLE    = PONG_RESET_PADDLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        upd_valid,
  input  logic [3:0]  upd_x,
  input  logic [3:0]  upd_y,
  input  logic [15:0] upd_lpaddle,
  input  logic [15:0] upd_rpaddle,
  output logic        upd_ready,
  output logic        tick,
  output logic        frame_start,
  output logic [3:0]  x,
  output logic [3:0]  y,
  output logic [15:0] lpaddle,
  output logic [15:0] rpaddle,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens in any cycle where upd_valid && upd_ready
  // are both high at the rising edge; upd_* are ignored otherwise.

  logic w_fs, w_due, w_fs_next, w_due_next;

  frame_timer #(
    .TIMERWIDTH      (TIMERWIDTH),
    .FRAMES_PER_TICK (FRAMES_PER_TICK)
  ) u_timer (
    .clk           (clk),
    .rst_n         (reset),
    .pause         (pause),
    .o_frame_start (w_fs),
    .o_due         (w_due),
    .o_fs_next     (w_fs_next),
    .o_due_next    (w_due_next)
  );

  sched_state_t r_state, w_state_n;

  logic        r_ready, r_tick, r_overrun;
  logic [3:0]  r_pend_x, r_pend_y, r_x, r_y;
  logic [15:0] r_pend_lp, r_pend_rp, r_lp, r_rp;

  logic        w_capture, w_tick_n, w_commit_n, w_overrun_n;
  logic [3:0]  w_pend_x, w_pend_y;
  logic [15:0] w_pend_lp, w_pend_rp;

  // r_state is the state in force this cycle; the outputs for next cycle are
  // derived from the next state and the timer's look-ahead so that tick and
  // commit land in the same cycle as the frame_start that triggers them.
  always_comb begin
    w_state_n = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: if (w_due) w_state_n = S_WAIT;
      S_WAIT: begin
        if (upd_valid) begin
          w_capture = 1'b1;
          w_state_n = S_HOLD;
        end
      end
      S_HOLD: if (w_fs) w_state_n = w_due ? S_WAIT : S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_pend_x    = w_capture ? upd_x       : r_pend_x;
    w_pend_y    = w_capture ? upd_y       : r_pend_y;
    w_pend_lp   = w_capture ? upd_lpaddle : r_pend_lp;
    w_pend_rp   = w_capture ? upd_rpaddle : r_pend_rp;
    // A due tick while the previous update is still outstanding is dropped.
    w_tick_n    = w_due_next && (w_state_n != S_WAIT);
    w_overrun_n = r_overrun || (w_due_next && (w_state_n == S_WAIT));
    w_commit_n  = w_fs_next && (w_state_n == S_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_tick    <= 1'b0;
      r_overrun <= 1'b0;
      r_pend_x  <= RESET_X;
      r_pend_y  <= RESET_Y;
      r_pend_lp <= RESET_PADDLE;
      r_pend_rp <= RESET_PADDLE;
      r_x       <= RESET_X;
      r_y       <= RESET_Y;
      r_lp      <= RESET_PADDLE;
      r_rp      <= RESET_PADDLE;
    end else begin
      r_state   <= w_state_n;
      r_ready   <= (w_state_n == S_WAIT);
      r_tick    <= w_tick_n;
      r_overrun <= w_overrun_n;
      r_pend_x  <= w_pend_x;
      r_pend_y  <= w_pend_y;
      r_pend_lp <= w_pend_lp;
      r_pend_rp <= w_pend_rp;
      if (w_commit_n) begin
        r_x  <= w_pend_x;
        r_y  <= w_pend_y;
        r_lp <= w_pend_lp;
        r_rp <= w_pend_rp;
      end
    end
  end

  assign upd_ready   = r_ready;
  assign tick        = r_tick;
  assign frame_start = w_fs;
  assign overrun     = r_overrun;
  assign x           = r_x;
  assign y           = r_y;
  assign lpaddle     = r_lp;
  assign rpaddle     = r_rp;
  assign dbg_state   = r_state;

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Paces game logic against the dot-matrix scan so ball and paddle positions change only on frame boundaries, with no tearing mid-scan. A free-running counter mirrors the screen's scan period and issues a game "tick" every FRAMES_PER_TICK frames. Game logic returns the next state over a valid/ready handshake, and the block double-buffers it. The shadow registers drive the screen block's x, y, lpaddle and rpaddle inputs directly.

Parameters:
TIMERWIDTH, 12, must match the screen block; frame length = 2^(TIMERWIDTH+5) clk cycles (16 rows x 2^(TIMERWIDTH+1)).
FRAMES_PER_TICK, 8, frames per game step; legal range 1..255.
RESET_X, 4'd7, ball column after reset.
RESET_Y, 4'd7, ball row after reset.
RESET_PADDLE, 16'h03C0, both paddle bitmaps after reset (rows 6-9).

Ports:
clk  in  1  12 MHz system clock
reset  in  1  asynchronous, active-low reset
pause  in  1  1 = suppress ticks; pending commits still complete
upd_valid  in  1  game logic offers next state
upd_x  in  4  next ball column
upd_y  in  4  next ball row
upd_lpaddle  in  16  next left paddle bitmap
upd_rpaddle  in  16  next right paddle bitmap
upd_ready  out  1  block accepts upd_* this cycle
tick  out  1  one-cycle pulse: compute next game state
frame_start  out  1  one-cycle pulse in the first cycle of each frame
x  out  4  displayed ball column
y  out  4  displayed ball row
lpaddle  out  16  displayed left paddle
rpaddle  out  16  displayed right paddle
overrun  out  1  sticky: a tick fell due while the previous update was still outstanding

Behaviour:
- Reset (reset=0, async): fc=0, fdiv=0, state=IDLE. Outputs: tick=0, frame_start=0, upd_ready=0, overrun=0, x=RESET_X, y=RESET_Y, lpaddle=rpaddle=RESET_PADDLE. Pending registers are cleared to the same values.
- fc: TIMERWIDTH+5 bits, increments every clk and wraps to 0.
- frame_start: registered; asserted in the cycle fc==0. Not asserted in the first cycle after reset release.
  - Aligned with screen rowtimer==0 when both blocks leave reset in the same cycle.
- fdiv: advances on each frame_start and wraps at FRAMES_PER_TICK-1.
- due: frame_start && fdiv==FRAMES_PER_TICK-1 && !pause.
- All outputs are registered. tick, and any commit, appear in the same cycle as the frame_start that triggers them.
- State machine, IDLE / WAIT / HOLD:
  - IDLE: upd_ready=0. On due: tick=1, go to WAIT.
  - WAIT: upd_ready=1. On upd_valid: capture upd_* into pending, upd_ready=0 next cycle, go to HOLD.
  - HOLD: upd_ready=0. On frame_start: copy pending to x/y/lpaddle/rpaddle, go to IDLE.
- Simultaneous events:
  - HOLD + frame_start + due: commit AND tick in the same cycle, go directly to WAIT.
  - WAIT + upd_valid + frame_start: capture only. The commit waits for the next frame_start, so every frame shows a single stable state.
  - WAIT + due: tick suppressed, overrun=1, stay in WAIT.
  - HOLD + due: commit, then go to WAIT with tick=1. This is not an overrun.
- overrun: once set, stays set until reset.
- pause: masks due only. fc and fdiv keep running, and a HOLD still commits.
- upd_* are ignored whenever upd_ready=0.
- Reset asserted mid-handshake: any pending data is discarded and the display returns to the reset values.

Decomposition:
- Package pong_pkg:
  - state enum (IDLE, WAIT, HOLD)
  - FRAME_BITS = TIMERWIDTH+5 helper
  - default reset-position constants, shared with the future game-logic block
- Sub-module frame_timer: holds fc, fdiv, the frame_start register and due generation. Parameterised by TIMERWIDTH and FRAMES_PER_TICK. frame_scheduler holds the FSM and the buffers.

Test Plan:
All scenarios run with TIMERWIDTH=1 (64-cycle frame) and FRAMES_PER_TICK=2.
- Release reset, idle 200 cycles -> frame_start at cycles 64/128/192 (fc==0); tick only at 128; x=7, y=7, paddles=03C0; upd_ready=0 except after tick.
- After tick at 128, drive upd_valid with x=3, y=9, lpaddle=000F, rpaddle=F000 at cycle 140 -> upd_ready drops at 141; outputs unchanged until 192, then show the new values at 192.
- Drive upd_valid in exactly cycle 192 (frame_start) while in WAIT -> captured; commit at 256, not 192.
- Withhold upd_valid through cycle 256 (next due) -> no tick at 256, overrun=1 and stays 1; a later update still commits on the following frame_start.
- pause=1 across cycle 256 from IDLE -> no tick, no overrun; frame_start continues; pause=0 -> tick at 384.
- Assert reset at cycle 170 while in HOLD with pending x=3 -> outputs return to the reset values immediately (async); after release, the first tick occurs 128 cycles later.
